// File: rtl/tv80_bus_wait_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tv80_bus_wait_ctrl_if : TV80 strobes, decode config and wait outputs |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface tv80_bus_wait_ctrl_if #(
  parameter int NUM_REGIONS = 4,
  parameter int WAIT_W      = 4
);
  logic                          mreq_n;
  logic                          iorq_n;
  logic                          rfsh_n;
  logic [15:0]                   A;
  logic [16*NUM_REGIONS-1:0]     region_base;
  logic [16*NUM_REGIONS-1:0]     region_mask;
  logic [WAIT_W*NUM_REGIONS-1:0] region_wait;
  logic [NUM_REGIONS-1:0]        region_rand;
  logic                          wait_n;
  logic [NUM_REGIONS-1:0]        cs;
  logic                          io_cs;
  logic                          miss;
  logic                          busy;
  logic [31:0]                   wait_total;

  modport master (
    output mreq_n, iorq_n, rfsh_n, A,
    output region_base, region_mask, region_wait, region_rand,
    input  wait_n, cs, io_cs, miss, busy, wait_total
  );

  modport slave (
    input  mreq_n, iorq_n, rfsh_n, A,
    input  region_base, region_mask, region_wait, region_rand,
    output wait_n, cs, io_cs, miss, busy, wait_total
  );
endinterface
`default_nettype wire

// File: rtl/tv80_bus_wait_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tv80_bus_wait_ctrl : region decoder, chip selects, wait-state stretch |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tv80_bus_wait_ctrl #(
  parameter int          NUM_REGIONS = 4,
  parameter int          WAIT_W      = 4,
  parameter int          IO_WAIT     = 1,
  parameter int          MISS_WAIT   = 0,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  wire logic             clk,
  input  wire logic             reset,
  tv80_bus_wait_ctrl_if.slave   bus
);

  localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
  localparam logic [WAIT_W-1:0] c_io_wait   = WAIT_W'(IO_WAIT);
  localparam logic [WAIT_W-1:0] c_miss_wait = WAIT_W'(MISS_WAIT);
  localparam logic [WAIT_W-1:0] c_one       = WAIT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t                 r_state, w_state_nx;
  logic [WAIT_W-1:0]      r_cnt, w_cnt_nx;
  logic [NUM_REGIONS-1:0] r_cs, w_cs_nx;
  logic                   r_io_cs, w_io_cs_nx;
  logic                   r_miss, w_miss_nx;
  logic [15:0]            r_lfsr, w_lfsr_nx;
  logic [31:0]            r_wait_total;

  logic [NUM_REGIONS-1:0] w_hit;
  logic [NUM_REGIONS-1:0] w_sel;
  logic [IDX_W-1:0]       w_idx;
  logic                   w_any;
  logic [WAIT_W-1:0]      w_wmax;
  logic [WAIT_W-1:0]      w_rand_cnt;
  logic [WAIT_W-1:0]      w_load;
  logic                   w_mem_start;
  logic                   w_io_start;
  logic                   w_bus_idle;
  logic                   w_lfsr_fb;

  assign w_mem_start = !bus.mreq_n && bus.rfsh_n;
  assign w_io_start  = !bus.iorq_n && bus.mreq_n;
  assign w_bus_idle  = bus.mreq_n && bus.iorq_n;
  assign w_lfsr_fb   = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGIONS; gi++) begin : g_hit
      assign w_hit[gi] = ((bus.A ^ bus.region_base[16*gi +: 16])
                          & bus.region_mask[16*gi +: 16]) == 16'h0000;
    end
  endgenerate

  // Descending scan so the lowest matching window is the one left selected.
  always_comb begin
    w_sel = '0;
    w_idx = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_sel    = '0;
        w_sel[i] = 1'b1;
        w_idx    = IDX_W'(i);
      end
    end
  end

  assign w_any      = |w_hit;
  assign w_wmax     = bus.region_wait[int'(w_idx)*WAIT_W +: WAIT_W];
  assign w_rand_cnt = WAIT_W'({1'b0, r_lfsr[WAIT_W-1:0]} % ({1'b0, w_wmax} + (WAIT_W+1)'(1)));

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_cs_nx    = r_cs;
    w_io_cs_nx = r_io_cs;
    w_miss_nx  = 1'b0;
    w_lfsr_nx  = r_lfsr;
    w_load     = '0;
    unique case (r_state)
      S_IDLE: begin
        if (w_mem_start || w_io_start) begin
          w_lfsr_nx = {r_lfsr[14:0], w_lfsr_fb};
          if (w_mem_start) begin
            if (w_any) begin
              w_cs_nx = w_sel;
              w_load  = bus.region_rand[w_idx] ? w_rand_cnt : w_wmax;
            end else begin
              w_miss_nx = 1'b1;
              w_load    = c_miss_wait;
            end
          end else begin
            w_io_cs_nx = 1'b1;
            w_load     = c_io_wait;
          end
          w_cnt_nx   = w_load;
          w_state_nx = (w_load != '0) ? S_WAIT : S_HOLD;
        end
      end
      S_WAIT: begin
        if (w_bus_idle) begin
          w_state_nx = S_IDLE;
          w_cs_nx    = '0;
          w_io_cs_nx = 1'b0;
        end else if (r_cnt <= c_one) begin
          w_state_nx = S_HOLD;
        end else begin
          w_cnt_nx = r_cnt - c_one;
        end
      end
      S_HOLD: begin
        if (w_bus_idle) begin
          w_state_nx = S_IDLE;
          w_cs_nx    = '0;
          w_io_cs_nx = 1'b0;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_cs_nx    = '0;
        w_io_cs_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_cs    <= '0;
      r_io_cs <= 1'b0;
      r_miss  <= 1'b0;
      r_lfsr  <= LFSR_SEED;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_cs    <= w_cs_nx;
      r_io_cs <= w_io_cs_nx;
      r_miss  <= w_miss_nx;
      r_lfsr  <= w_lfsr_nx;
    end
  end

  // wait_n is low exactly while in S_WAIT, so count those cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wait_total <= '0;
    end else if (r_state == S_WAIT && r_wait_total != 32'hFFFF_FFFF) begin
      r_wait_total <= r_wait_total + 32'd1;
    end
  end

  assign bus.wait_n     = (r_state != S_WAIT);
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.cs         = r_cs;
  assign bus.io_cs      = r_io_cs;
  assign bus.miss       = r_miss;
  assign bus.wait_total = r_wait_total;

endmodule
`default_nettype wire
